// File: rtl/sme_pkg.sv
// Shared types, character constants and the per-position match rule for sme_multi.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_STR,
    S_LOAD_PAT,
    S_SCAN,
    S_DONE
  } state_t;

  // Characters are compared at this width so one helper serves any CHAR_W up to 32.
  localparam int CHAR_MAX_W = 32;

  localparam logic [CHAR_MAX_W-1:0] CH_SPACE  = 32'h20;
  localparam logic [CHAR_MAX_W-1:0] CH_CARET  = 32'h5E;
  localparam logic [CHAR_MAX_W-1:0] CH_DOLLAR = 32'h24;
  localparam logic [CHAR_MAX_W-1:0] CH_DOT    = 32'h2E;

  // One pattern character against one string position. Virtual positions
  // (S[-1], S[str_len]) already read as space; '.' must still reject them.
  function automatic logic pat_char_match(input logic [CHAR_MAX_W-1:0] p,
                                          input logic [CHAR_MAX_W-1:0] s,
                                          input logic                  is_virtual);
    logic r;
    if (p == CH_CARET || p == CH_DOLLAR) r = (s == CH_SPACE);
    else if (p == CH_DOT)                r = !is_virtual;
    else                                 r = (p == s);
    return r;
  endfunction

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational compare of the stored pattern against the string window at one candidate.
module sme_window_cmp
  import sme_pkg::*;
#(
  parameter int PAT_DEPTH = 8,
  parameter int CHAR_W    = 8,
  parameter int PL_W      = $clog2(PAT_DEPTH + 1)
) (
  input  logic [PAT_DEPTH-1:0][CHAR_W-1:0] pat,
  input  logic [PAT_DEPTH-1:0][CHAR_W-1:0] win,
  input  logic [PAT_DEPTH-1:0]             win_virt,
  input  logic [PAT_DEPTH-1:0]             win_ok,
  input  logic [PL_W-1:0]                  pat_len,
  output logic                             hit
);

  logic [PAT_DEPTH-1:0] lane_ok;

  // Lanes past pat_len are don't-care; live lanes must sit inside S[-1..str_len] and match.
  for (genvar i = 0; i < PAT_DEPTH; i++) begin : g_lane
    assign lane_ok[i] = (PL_W'(i) >= pat_len) ||
                        (win_ok[i] && pat_char_match(CHAR_MAX_W'(pat[i]),
                                                     CHAR_MAX_W'(win[i]),
                                                     win_virt[i]));
  end

  assign hit = &lane_ok;

endmodule

// File: rtl/sme_multi.sv
// String-matching engine: loads a string and patterns, scans one candidate per cycle.
module sme_multi
  import sme_pkg::*;
#(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int CHAR_W    = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              find_last,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    match_count
);

  localparam int SL_W  = IDX_W + 1;
  localparam int PL_W  = $clog2(PAT_DEPTH + 1);
  localparam int PA_W  = $clog2(PAT_DEPTH);
  localparam int CW    = $clog2(STR_DEPTH + PAT_DEPTH + 2) + 2;
  localparam int CNT_W = IDX_W + 1;
  localparam logic signed [CW-1:0] NEG1 = '1;

  state_t state, state_nx;

  logic [CHAR_W-1:0]                str_mem [STR_DEPTH];
  logic [PAT_DEPTH-1:0][CHAR_W-1:0] pat_q;
  logic [SL_W-1:0]                  str_len;
  logic [PL_W-1:0]                  pat_len;
  logic                             find_last_q;
  logic signed [CW-1:0]             cand;
  logic signed [CW-1:0]             sl_s;

  logic str_we, str_clr, pat_we, pat_clr, scan_act, last;
  logic [SL_W-1:0] str_wa;
  logic [PL_W-1:0] pat_wa;

  logic [PAT_DEPTH-1:0][CHAR_W-1:0] win;
  logic [PAT_DEPTH-1:0]             win_virt, win_ok;
  logic                             hit;
  logic [IDX_W-1:0]                 rep_idx;

  logic             acc_found, acc_found_nx;
  logic [IDX_W-1:0] acc_idx, acc_idx_nx;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_nx;

  assign sl_s = $signed(CW'(str_len));
  assign last = (cand == sl_s);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and load/scan strobes. The first low-ispattern cycle already
  // evaluates candidate -1, so valid lands exactly str_len+2 cycles later.
  always_comb begin
    state_nx = state;
    str_we   = 1'b0;
    str_clr  = 1'b0;
    pat_we   = 1'b0;
    pat_clr  = 1'b0;
    scan_act = 1'b0;
    case (state)
      S_IDLE: begin
        if (isstring) begin
          state_nx = S_LOAD_STR;
          str_clr  = 1'b1;
          str_we   = 1'b1;
        end else if (ispattern) begin
          state_nx = S_LOAD_PAT;
          pat_clr  = 1'b1;
          pat_we   = 1'b1;
        end
      end
      S_LOAD_STR: begin
        if (isstring) str_we   = 1'b1;
        else          state_nx = S_IDLE;
      end
      S_LOAD_PAT: begin
        if (!ispattern) begin
          scan_act = 1'b1;
          state_nx = S_SCAN;
        end else if (!isstring) begin
          pat_we = 1'b1;
        end
      end
      S_SCAN: begin
        scan_act = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign str_wa = str_clr ? '0 : str_len;
  assign pat_wa = pat_clr ? '0 : pat_len;

  // Character storage; writes past the depth are dropped.
  always_ff @(posedge clk) begin
    if (str_we && str_wa < SL_W'(STR_DEPTH)) str_mem[str_wa[IDX_W-1:0]] <= chardata;
    if (pat_we && pat_wa < PL_W'(PAT_DEPTH)) pat_q[pat_wa[PA_W-1:0]]    <= chardata;
  end

  // String window at the current candidate; out-of-string positions read as space.
  for (genvar i = 0; i < PAT_DEPTH; i++) begin : g_win
    logic signed [CW-1:0] pos;
    assign pos         = cand + CW'(i);
    assign win_virt[i] = (pos == NEG1) || (pos == sl_s);
    assign win_ok[i]   = (pos <= sl_s);
    assign win[i]      = (!pos[CW-1] && pos < sl_s) ? str_mem[pos[IDX_W-1:0]]
                                                    : CH_SPACE[CHAR_W-1:0];
  end

  sme_window_cmp #(
    .PAT_DEPTH (PAT_DEPTH),
    .CHAR_W    (CHAR_W),
    .PL_W      (PL_W)
  ) u_cmp (
    .pat      (pat_q),
    .win      (win),
    .win_virt (win_virt),
    .win_ok   (win_ok),
    .pat_len  (pat_len),
    .hit      (hit)
  );

  // A leading '^' consumes the space before the word, so report one past the start.
  assign rep_idx = (pat_q[0] == CH_CARET[CHAR_W-1:0]) ? IDX_W'(cand + 1) : IDX_W'(cand);

  // Accumulator update for this candidate.
  always_comb begin
    acc_found_nx = acc_found | hit;
    acc_idx_nx   = acc_idx;
    acc_cnt_nx   = acc_cnt;
    if (hit) begin
      if (!acc_found || find_last_q) acc_idx_nx = rep_idx;
      if (acc_cnt != '1)             acc_cnt_nx = acc_cnt + 1'b1;
    end
  end

  // Lengths, candidate counter, accumulators and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_len     <= '0;
      pat_len     <= '0;
      find_last_q <= 1'b0;
      cand        <= NEG1;
      acc_found   <= 1'b0;
      acc_idx     <= '0;
      acc_cnt     <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
    end else begin
      if (str_clr)                                  str_len <= SL_W'(1);
      else if (str_we && str_len < SL_W'(STR_DEPTH)) str_len <= str_len + 1'b1;

      if (pat_clr)                                  pat_len <= PL_W'(1);
      else if (pat_we && pat_len < PL_W'(PAT_DEPTH)) pat_len <= pat_len + 1'b1;

      if (pat_clr) begin
        find_last_q <= find_last;
        cand        <= NEG1;
        acc_found   <= 1'b0;
        acc_idx     <= '0;
        acc_cnt     <= '0;
      end else if (scan_act) begin
        cand      <= cand + 1'b1;
        acc_found <= acc_found_nx;
        acc_idx   <= acc_idx_nx;
        acc_cnt   <= acc_cnt_nx;
      end

      valid <= scan_act && last;
      if (scan_act && last) begin
        match       <= acc_found_nx;
        match_index <= acc_idx_nx;
        match_count <= acc_cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_sme_multi.sv
// Bench for sme_multi: directed cases plus random strings/patterns against a loop-based model.
module tb_sme_multi;

  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring, ispattern, find_last;
  logic             valid, match;
  logic [IDX_W-1:0] match_index;
  logic [IDX_W:0]   match_count;

  int    total = 0;
  int    bad   = 0;
  string cur_str = "";

  always #5 clk = ~clk;

  sme_multi #(.STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .CHAR_W(8), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .find_last   (find_last),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .match_count (match_count)
  );

  // Reference: try every start position against the truncated string with padded ends.
  function automatic void ref_scan(input string s, input string p, input bit fl,
                                   output bit m, output int idx, output int cnt, output int lat);
    int  sl, pl, pos, r;
    bit  ok, virt;
    byte sc, pc;
    sl = (s.len() > STR_DEPTH) ? STR_DEPTH : s.len();
    pl = (p.len() > PAT_DEPTH) ? PAT_DEPTH : p.len();
    m = 0; idx = 0; cnt = 0; lat = sl + 2;
    for (int pp = -1; pp <= sl; pp++) begin
      ok = (pp + pl - 1 <= sl);
      for (int i = 0; i < pl && ok; i++) begin
        pos  = pp + i;
        virt = (pos < 0) || (pos >= sl);
        sc   = virt ? 8'h20 : s[pos];
        pc   = p[i];
        if (pc == 8'h5E || pc == 8'h24) ok = (sc == 8'h20);
        else if (pc == 8'h2E)           ok = !virt;
        else                            ok = (pc == sc);
      end
      if (ok) begin
        if (cnt < 63) cnt++;
        r = (p[0] == 8'h5E) ? pp + 1 : pp;
        if (!m || fl) idx = r & ((1 << IDX_W) - 1);
        m = 1;
      end
    end
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      isstring = 1'b1;
      chardata = s[i];
    end
    @(posedge clk); #1;
    isstring = 1'b0;
    cur_str  = s;
  endtask

  // Streams a pattern (find_last toggled after the first char) and waits for valid.
  task automatic run_pat(input string p, input bit fl, output bit pre_v, output bit got,
                         output int lat, output bit m, output int idx, output int cnt);
    pre_v = 1'b0;
    for (int i = 0; i < p.len(); i++) begin
      @(posedge clk); #1;
      if (i == 0) pre_v = valid;
      ispattern = 1'b1;
      chardata  = p[i];
      find_last = (i == 0) ? fl : !fl;
    end
    @(posedge clk); #1;
    ispattern = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    m   = match;
    idx = match_index;
    cnt = match_count;
  endtask

  task automatic test_reset();
    reset = 1'b1; isstring = 0; ispattern = 0; find_last = 0; chardata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%0d exp=0", valid); end
    total++; if (match !== 1'b0)     begin bad++; $display("FAIL reset_match got=%0d exp=0", match); end
    total++; if (match_index !== '0) begin bad++; $display("FAIL reset_index got=%0d exp=0", match_index); end
    total++; if (match_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", match_count); end
  endtask

  task automatic test_directed();
    string dp  [10] = '{"wor", "^wo", "o", "o", "d$", "h.l", "^hello$", "o.w", "xyz", "world!"};
    bit    dfl [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit    dm  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int    didx[10] = '{6, 6, 4, 7, 10, 0, 0, 4, 0, 0};
    int    dcnt[10] = '{1, 1, 2, 2, 1, 1, 1, 1, 0, 0};
    bit pre_v, got, m; int lat, idx, cnt;
    load_str("hello world");
    for (int t = 0; t < 10; t++) begin
      run_pat(dp[t], dfl[t], pre_v, got, lat, m, idx, cnt);
      total++; if (pre_v !== 1'b0) begin bad++; $display("FAIL dir_valid_pulse %s got=%0d exp=0", dp[t], pre_v); end
      total++; if (got !== 1'b1 || lat != 13) begin bad++; $display("FAIL dir_latency %s got=%0d/%0d exp=1/13", dp[t], got, lat); end
      total++; if (m !== dm[t]) begin bad++; $display("FAIL dir_match %s got=%0d exp=%0d", dp[t], m, dm[t]); end
      total++; if (idx != didx[t]) begin bad++; $display("FAIL dir_index %s got=%0d exp=%0d", dp[t], idx, didx[t]); end
      total++; if (cnt != dcnt[t]) begin bad++; $display("FAIL dir_count %s got=%0d exp=%0d", dp[t], cnt, dcnt[t]); end
    end
  endtask

  task automatic test_abort();
    string p = "wor";
    bit pre_v, got, m; int lat, idx, cnt, seen;
    run_pat(p, 1'b0, pre_v, got, lat, m, idx, cnt);
    total++; if (m !== 1'b1) begin bad++; $display("FAIL abort_setup got=%0d exp=1", m); end
    for (int i = 0; i < p.len(); i++) begin
      @(posedge clk); #1; ispattern = 1'b1; chardata = p[i]; find_last = 1'b0;
    end
    @(posedge clk); #1; ispattern = 1'b0;         // T0
    repeat (3) @(posedge clk);                    // T0+3
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    cur_str = "";
    total++; if (match !== 1'b0 || match_index !== '0 || match_count !== '0)
      begin bad++; $display("FAIL abort_outputs got=%0d/%0d/%0d exp=0/0/0", match, match_index, match_count); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (valid) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
    run_pat("^$", 1'b0, pre_v, got, lat, m, idx, cnt);
    total++; if (got !== 1'b1 || lat != 2) begin bad++; $display("FAIL empty_latency got=%0d/%0d exp=1/2", got, lat); end
    total++; if (m !== 1'b1 || idx != 0 || cnt != 1)
      begin bad++; $display("FAIL empty_result got=%0d/%0d/%0d exp=1/0/1", m, idx, cnt); end
  endtask

  task automatic test_trunc();
    string s = "";
    string pl [3] = '{"b$", "bb", "a"};
    bit    fl [3] = '{0, 0, 1};
    bit    em [3] = '{1, 0, 1};
    int    ei [3] = '{31, 0, 30};
    int    ec [3] = '{1, 0, 31};
    bit pre_v, got, m; int lat, idx, cnt;
    for (int i = 0; i < 40; i++) s = {s, (i < 31) ? "a" : "b"};
    load_str(s);
    for (int t = 0; t < 3; t++) begin
      run_pat(pl[t], fl[t], pre_v, got, lat, m, idx, cnt);
      total++; if (got !== 1'b1 || lat != 34) begin bad++; $display("FAIL trunc_latency %s got=%0d/%0d exp=1/34", pl[t], got, lat); end
      total++; if (m !== em[t] || idx != ei[t] || cnt != ec[t])
        begin bad++; $display("FAIL trunc_result %s got=%0d/%0d/%0d exp=%0d/%0d/%0d", pl[t], m, idx, cnt, em[t], ei[t], ec[t]); end
    end
  endtask

  task automatic test_both_strobes();
    bit pre_v, got, m; int lat, idx, cnt;
    @(posedge clk); #1; isstring = 1'b1; chardata = "q";
    @(posedge clk); #1; ispattern = 1'b1; chardata = "z";
    @(posedge clk); #1; isstring = 1'b0; ispattern = 1'b0;
    cur_str = "qz";
    run_pat("qz$", 1'b0, pre_v, got, lat, m, idx, cnt);
    total++; if (got !== 1'b1 || lat != 4) begin bad++; $display("FAIL both_latency got=%0d/%0d exp=1/4", got, lat); end
    total++; if (m !== 1'b1 || idx != 0 || cnt != 1)
      begin bad++; $display("FAIL both_result got=%0d/%0d/%0d exp=1/0/1", m, idx, cnt); end
  endtask

  task automatic test_random();
    string sa = "ab ";
    string pa = "ab.^$ ";
    string s, p;
    bit pre_v, got, m, em, fl; int lat, idx, cnt, ei, ec, el, n;
    for (int r = 0; r < 4; r++) begin
      s = "";
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        int k; k = $urandom_range(2, 0); s = {s, sa.substr(k, k)};
      end
      load_str(s);
      for (int q = 0; q < 10; q++) begin
        int k;
        p = "";
        n = $urandom_range(10, 1);
        for (int i = 0; i < n; i++) begin
          k = (i == 0) ? $urandom_range(3, 0) : $urandom_range(5, 0);
          p = {p, pa.substr(k, k)};
        end
        fl = 1'($urandom_range(1, 0));
        ref_scan(cur_str, p, fl, em, ei, ec, el);
        run_pat(p, fl, pre_v, got, lat, m, idx, cnt);
        total++; if (got !== 1'b1 || lat != el)
          begin bad++; $display("FAIL rnd_latency s='%s' p='%s' got=%0d/%0d exp=1/%0d", cur_str, p, got, lat, el); end
        total++; if (m !== em || idx != ei || cnt != ec)
          begin bad++; $display("FAIL rnd_result s='%s' p='%s' fl=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                cur_str, p, fl, m, idx, cnt, em, ei, ec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_trunc();
    test_both_strobes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sme_multi.md
# sme_multi

Parametrised string-matching engine, successor to the fixed 32-char SME. Loads a string, then any number of patterns one character per cycle, and reports match status, first or last match index, and total match count for each pattern. Supports the `^`, `$` and `.` wildcards. Depth and character width are generic, and scan latency is deterministic. Sits behind the character-stream front end, on the same load/valid protocol as the SME testbench flow.

## Interface

**Parameters**
- `STR_DEPTH`, default 32: maximum stored string length.
- `PAT_DEPTH`, default 8: maximum stored pattern length.
- `CHAR_W`, default 8: character width.
- `IDX_W`, default `$clog2(STR_DEPTH)`: index width.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `chardata` in `CHAR_W`: current string or pattern character.
- `isstring` in 1: `chardata` is a string character.
- `ispattern` in 1: `chardata` is a pattern character.
- `find_last` in 1: sampled with the first pattern character. 0 reports the lowest match index, 1 reports the highest.
- `valid` out 1: one-cycle result strobe.
- `match` out 1: at least one match found.
- `match_index` out `IDX_W`: reported index; 0 when `match`=0.
- `match_count` out `IDX_W+1`: number of matching start positions.

## Operation

**States:** IDLE, LOAD_STR, LOAD_PAT, SCAN, DONE.
- IDLE to LOAD_STR on `isstring`.
- IDLE to LOAD_PAT on `ispattern`.
- LOAD_STR/LOAD_PAT to SCAN (pattern) or IDLE (string) on the first cycle the strobe is low.
- SCAN to DONE after the last candidate.
- DONE to IDLE unconditionally.

**Loading**
- A new string (first `isstring` after any non-string cycle) clears the string length, then stores characters.
- The string persists across patterns until the next string or `reset`.
- `isstring` and `ispattern` high together: `isstring` wins and the pattern character is dropped.
- Characters beyond `STR_DEPTH` or `PAT_DEPTH` are discarded (truncation). `str_len` and `pat_len` saturate.

**Virtual padding**
- S[-1] and S[str_len] read as space (0x20).

**Pattern characters**
- `^` matches only a space, including S[-1].
- `$` matches only a space, including S[str_len].
- `.` matches any stored character, but not a virtual position.
- Any other character matches by exact equality.

**Candidates**
- Start positions p = -1 .. str_len, one per cycle, in ascending order.
- A candidate matches when all `pat_len` positions match and p+pat_len-1 ≤ str_len.

**Reported index**
- p+1 if P[0] is `^`, otherwise p.
- With `find_last`=0, the first hit is kept.
- With `find_last`=1, every hit overwrites the stored index.

**Count**
- Counts every matching candidate.
- Saturates at 2^(IDX_W+1)-1.

**Ignored inputs**
- Inputs are ignored during SCAN and DONE. Upstream must not stream during these states.

**Reset values**
- `valid`=0, `match`=0, `match_index`=0, `match_count`=0.
- `str_len`=0, `pat_len`=0, state IDLE.
- Reset mid-load or mid-scan aborts with no `valid`.

## Timing

- T0 is the first cycle with `ispattern`=0 after a pattern load.
- SCAN occupies T0 .. T0+str_len+1, covering str_len+2 candidates.
- `valid` is high for exactly the cycle T0+str_len+2.
- Outputs are registered. `match`, `match_index` and `match_count` hold their values until the next DONE or `reset`.
- Empty string (str_len=0): two candidates, `valid` at T0+2.
- Empty pattern is impossible because a load is at least one cycle.
- Back-to-back pattern: the next pattern may start in the cycle after `valid`.

## Structure

**Package `sme_pkg`**
- `state_t` enum.
- Constants `CH_SPACE`=0x20, `CH_CARET`=0x5E, `CH_DOLLAR`=0x24, `CH_DOT`=0x2E.
- Function `pat_char_match(p, s, is_virtual)`.

**Sub-module `sme_window_cmp`**
- Combinational.
- Compares `PAT_DEPTH` pattern characters against the `PAT_DEPTH`-wide string window at the current candidate.
- Per-position mask from `pat_len`.
- Outputs `hit`.

**Top**
- FSM, string/pattern register files, candidate counter, index/count accumulators.

## Test plan

All scenarios use string "hello world" (str_len=11), `STR_DEPTH`=32, `PAT_DEPTH`=8 unless noted.

1. Pattern "wor", `find_last`=0 → `valid` at T0+13; `match`=1, `index`=6, `count`=1.
2. Pattern "^wo" → `match`=1, `index`=6.
   Pattern "o" with `find_last`=0 → `index`=4, `count`=2.
   Pattern "o" with `find_last`=1 → `index`=7, `count`=2.
3. Pattern "d$" → `index`=10.
   Pattern "h.l" → `index`=0.
   Pattern "^hello$" → `index`=0.
   Pattern "o.w" → `index`=4.
4. Pattern "xyz" → `match`=0, `index`=0, `count`=0.
   Pattern "world!" → `match`=0, because the end is exceeded.
5. `reset` at T0+3 of a scan → no `valid`, all outputs 0.
   Next, pattern "^$" with no new string → `valid` at T0+2; `match`=1, `index`=0, `count`=1.
6. 40-character string "a"×31 followed by "b"×9 → stored 31 "a" and one "b".
   Pattern "b$" → `index`=31.
   Pattern "bb" → `match`=0.
   `isstring` and `ispattern` high together in one cycle → character stored as string.
